multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle control by stepping one instruction through fetch, decode, execute, memory and write-back states over several clocks. It drives the shared ALU, register file, PC and unified instruction/data memory select lines, and stalls on a memory ready handshake. A watchdog counter aborts stuck memory accesses.

## Interface

Parameters:
- WAIT_LIMIT, default 15: maximum consecutive not-ready cycles tolerated in any memory state (must be ≥ 1).

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction bits 31:26 from the instruction register.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result register.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write-data select: 1 = memory data register.
- RegDst  out  1  destination select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- ALUOp  out  2  to the ALU control decoder: 00 = add, 01 = subtract, 10 = decode funct.
- PCSource  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- state  out  4  current state code, for debug.
- illegal_op  out  1  one-cycle pulse: an unknown opcode was decoded.
- mem_timeout  out  1  one-cycle pulse: a memory access was aborted.

## Operation

- Control outputs are Moore decodes of `state`. Exceptions: in FETCH, IRWrite and PCWrite equal `mem_ready`. Any output not listed for a state is 0.
- State codes and transitions:
  - 0 FETCH: MemRead, ALUSrcB=01. On `mem_ready` → DECODE; otherwise stay.
  - 1 DECODE: ALUSrcB=11. Dispatches on `opcode`:
    - 000000 → EXECUTE
    - 100011 or 101011 → MEM_ADDR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDI_EXEC
    - any other opcode → FETCH, with `illegal_op` set for the next cycle.
  - 2 MEM_ADDR: ALUSrcA, ALUSrcB=10. Goes to MEM_READ for 100011, MEM_WRITE for 101011.
  - 3 MEM_READ: MemRead, IorD. On `mem_ready` → MEM_WB.
  - 4 MEM_WB: RegWrite, MemtoReg. → FETCH.
  - 5 MEM_WRITE: MemWrite, IorD. On `mem_ready` → FETCH.
  - 6 EXECUTE: ALUSrcA, ALUOp=10. → ALU_WB.
  - 7 ALU_WB: RegDst, RegWrite. → FETCH.
  - 8 BRANCH: ALUSrcA, ALUOp=01, PCWriteCond, PCSource=01. → FETCH.
  - 9 JUMP: PCWrite, PCSource=10. → FETCH.
  - 10 ADDI_EXEC: ALUSrcA, ALUSrcB=10. → ADDI_WB.
  - 11 ADDI_WB: RegWrite. → FETCH.
  - Codes 12–15 are unreachable; if entered, go to FETCH.
- Wait states are FETCH, MEM_READ and MEM_WRITE.
- Watchdog:
  - `wait_cnt` is cleared on entry to any wait state.
  - It increments on each wait-state cycle with `mem_ready`=0, and is 0 outside wait states.
  - If `wait_cnt` == WAIT_LIMIT-1 and `mem_ready`=0, the next state is FETCH and `mem_timeout` is set for the next cycle. A FETCH abort re-enters FETCH with `wait_cnt` cleared.
  - `mem_ready`=1 on the limit cycle wins: normal transition, no timeout.
  - Counter width is clog2(WAIT_LIMIT), minimum 1; it never wraps.
- `opcode` is sampled only in DECODE and MEM_ADDR.

## Timing

- Reset (asynchronous, immediate):
  - `state`=0 (FETCH), `wait_cnt`=0, `illegal_op`=0, `mem_timeout`=0.
  - Outputs therefore read MemRead=1, ALUSrcB=01, all others 0, with IRWrite and PCWrite following `mem_ready`.
- Reset asserted mid-instruction abandons it. No write enable may remain asserted after the reset edge.
- Cycles per instruction with `mem_ready` constantly 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of `mem_ready`=0 in a wait state adds exactly one cycle.
- `illegal_op` and `mem_timeout` are registered and high for exactly one cycle, the first cycle back in FETCH.
- Outputs are glitch-free from registered state, apart from the `mem_ready` gating in FETCH.

## Test plan

- Reset held, then released with `mem_ready`=1 and opcode 100011 → `state` sequence 0,1,2,3,4,0; RegWrite=MemtoReg=1 only in state 4; IRWrite/PCWrite high in state 0 only.
- R-type (000000) then beq (000100), `mem_ready`=1 → states 0,1,6,7,0,1,8,0; ALUOp=10 in 6; PCWriteCond=1 and PCSource=01 in 8.
- sw (101011) with `mem_ready` low for 3 cycles in MEM_WRITE → MemWrite high for 4 cycles; total 7 cycles; no timeout.
- WAIT_LIMIT=4, `mem_ready` held 0 in MEM_READ → after 4 cycles `state`=0, `mem_timeout` high one cycle, RegWrite never asserted.
- Opcode 111111 in DECODE → `state` 1→0, `illegal_op`=1 for one cycle; next fetch proceeds normally.
- Rst pulsed asynchronously mid-clock during ALU_WB → `state`=0 and RegWrite=0 immediately, before the next Clk edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | multicycle_ctrl                                                        |
// | Multi-cycle MIPS sequencer with memory handshake and access watchdog.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam int c_cnt_w = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WAIT_LIMIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_addi  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Moore control word for a state; FETCH's IRWrite/PCWrite are gated separately.
  function automatic ctrl_t f_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDI_WB:   c.reg_write = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  state_t             r_state;
  ctrl_t              r_ctrl;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_illegal;
  logic               r_timeout;

  state_t             w_next;
  logic               w_illegal;
  logic               w_timeout;
  logic               w_is_wait;
  logic               w_in_fetch;
  logic [c_cnt_w-1:0] w_cnt_next;

  always_comb begin
    w_next     = r_state;
    w_illegal  = 1'b0;
    w_timeout  = 1'b0;
    w_cnt_next = '0;
    w_in_fetch = (r_state == S_FETCH);
    w_is_wait  = w_in_fetch || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);

    case (r_state)
      S_FETCH:     if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          c_op_rtype:       w_next = S_EXECUTE;
          c_op_lw, c_op_sw: w_next = S_MEM_ADDR;
          c_op_beq:         w_next = S_BRANCH;
          c_op_j:           w_next = S_JUMP;
          c_op_addi:        w_next = S_ADDI_EXEC;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == c_op_lw)      w_next = S_MEM_READ;
        else if (opcode == c_op_sw) w_next = S_MEM_WRITE;
        else                        w_next = S_FETCH;
      end
      S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECUTE:   w_next = S_ALU_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      default:     w_next = S_FETCH;
    endcase

    // A ready on the limit cycle takes priority over the abort.
    if (w_is_wait && !mem_ready && (r_wait_cnt == c_cnt_last)) begin
      w_next    = S_FETCH;
      w_timeout = 1'b1;
    end

    // Counter is zero outside wait states, so entering one always starts from 0.
    if (w_is_wait && !mem_ready && !w_timeout) begin
      w_cnt_next = r_wait_cnt + c_cnt_one;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= S_FETCH;
      r_ctrl     <= f_decode(S_FETCH);
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ctrl     <= f_decode(w_next);
      r_wait_cnt <= w_cnt_next;
      r_illegal  <= w_illegal;
      r_timeout  <= w_timeout;
    end
  end

  assign PCWrite     = r_ctrl.pc_write | (w_in_fetch & mem_ready);
  assign IRWrite     = w_in_fetch & mem_ready;
  assign PCWriteCond = r_ctrl.pc_write_cond;
  assign IorD        = r_ctrl.iord;
  assign MemRead     = r_ctrl.mem_read;
  assign MemWrite    = r_ctrl.mem_write;
  assign MemtoReg    = r_ctrl.mem_to_reg;
  assign RegDst      = r_ctrl.reg_dst;
  assign RegWrite    = r_ctrl.reg_write;
  assign ALUSrcA     = r_ctrl.alu_src_a;
  assign ALUSrcB     = r_ctrl.alu_src_b;
  assign ALUOp       = r_ctrl.alu_op;
  assign PCSource    = r_ctrl.pc_source;
  assign state       = r_state;
  assign illegal_op  = r_illegal;
  assign mem_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_multicycle_ctrl                                                     |
// | Randomized trace-based bench for the multi-cycle sequencer.            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_multicycle_ctrl;

  localparam int LIMIT = 4;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MADDR = 4'd2,
                         ST_MREAD = 4'd3,  ST_MWB    = 4'd4,  ST_MWRITE = 4'd5,
                         ST_EXEC  = 4'd6,  ST_ALUWB  = 4'd7,  ST_BRANCH = 4'd8,
                         ST_JUMP  = 4'd9,  ST_AEXEC  = 4'd10, ST_AWB    = 4'd11;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       illegal_op, mem_timeout;
  logic [15:0] act_ctrl;

  multicycle_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
    .Clk(clk), .Rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  assign act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic [5:0] op;
    logic       ill;
    logic       to;
  } entry_t;

  entry_t q[$];
  int     vectors = 0;
  int     miscompares = 0;
  bit     pend_ill = 1'b0;
  bit     pend_to = 1'b0;

  // Output table straight from the state list; same packing as act_ctrl.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      ST_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE: asb = 2'b11;
      ST_MADDR:  begin asa = 1; asb = 2'b10; end
      ST_MREAD:  begin mr = 1; iord = 1; end
      ST_MWB:    begin rw = 1; m2r = 1; end
      ST_MWRITE: begin mw = 1; iord = 1; end
      ST_EXEC:   begin asa = 1; aop = 2'b10; end
      ST_ALUWB:  begin rd = 1; rw = 1; end
      ST_BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      ST_JUMP:   begin pcw = 1; pcs = 2'b10; end
      ST_AEXEC:  begin asa = 1; asb = 2'b10; end
      ST_AWB:    rw = 1;
      default:   ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
  endfunction

  task automatic add(input logic [3:0] st, input logic rdy, input logic [5:0] op);
    entry_t e;
    e.st = st; e.rdy = rdy; e.op = op; e.ill = pend_ill; e.to = pend_to;
    pend_ill = 1'b0;
    pend_to  = 1'b0;
    q.push_back(e);
  endtask

  // Wait state stalled for 'stall' cycles; a stall reaching LIMIT aborts to FETCH.
  task automatic add_wait(input logic [3:0] st, input int stall, input logic [5:0] op,
                          output bit aborted);
    int n;
    n = (stall >= LIMIT) ? LIMIT : stall;
    for (int i = 0; i < n; i++) add(st, 1'b0, op);
    aborted = (stall >= LIMIT);
    if (aborted) pend_to = 1'b1;
    else         add(st, 1'b1, op);
  endtask

  task automatic add_instr(input logic [5:0] op, input int fstall, input int mstall);
    bit ab;
    logic r;
    add_wait(ST_FETCH, fstall, op, ab);
    while (ab) add_wait(ST_FETCH, 0, op, ab);
    r = 1'($urandom_range(0, 1));
    add(ST_DECODE, r, op);
    r = 1'($urandom_range(0, 1));
    case (op)
      OP_LW: begin
        add(ST_MADDR, r, op);
        add_wait(ST_MREAD, mstall, op, ab);
        if (!ab) add(ST_MWB, 1'($urandom_range(0, 1)), op);
      end
      OP_SW: begin
        add(ST_MADDR, r, op);
        add_wait(ST_MWRITE, mstall, op, ab);
      end
      OP_R:    begin add(ST_EXEC, r, op);  add(ST_ALUWB, 1'($urandom_range(0, 1)), op); end
      OP_BEQ:  add(ST_BRANCH, r, op);
      OP_J:    add(ST_JUMP, r, op);
      OP_ADDI: begin add(ST_AEXEC, r, op); add(ST_AWB, 1'($urandom_range(0, 1)), op); end
      default: pend_ill = 1'b1;
    endcase
  endtask

  task automatic run_trace(input string name);
    entry_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      opcode    = e.op;
      mem_ready = e.rdy;
      #1;
      vectors++;
      if (state !== e.st) begin
        miscompares++;
        $display("FAIL %s state: got %0d expected %0d", name, state, e.st);
      end
      vectors++;
      if (act_ctrl !== exp_ctrl(e.st, e.rdy)) begin
        miscompares++;
        $display("FAIL %s ctrl(st=%0d): got %h expected %h", name, e.st, act_ctrl,
                 exp_ctrl(e.st, e.rdy));
      end
      vectors++;
      if (illegal_op !== e.ill) begin
        miscompares++;
        $display("FAIL %s illegal_op(st=%0d): got %b expected %b", name, e.st, illegal_op, e.ill);
      end
      vectors++;
      if (mem_timeout !== e.to) begin
        miscompares++;
        $display("FAIL %s mem_timeout(st=%0d): got %b expected %b", name, e.st, mem_timeout, e.to);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; opcode = OP_LW;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (state !== ST_FETCH || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got st=%0d ill=%b to=%b expected 0/0/0", state, illegal_op, mem_timeout);
    end
    vectors++;
    if (act_ctrl !== exp_ctrl(ST_FETCH, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_ctrl_rdy0: got %h expected %h", act_ctrl, exp_ctrl(ST_FETCH, 1'b0));
    end
    mem_ready = 1'b1;
    #1;
    vectors++;
    if (act_ctrl !== exp_ctrl(ST_FETCH, 1'b1)) begin
      miscompares++;
      $display("FAIL reset_ctrl_rdy1: got %h expected %h", act_ctrl, exp_ctrl(ST_FETCH, 1'b1));
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_lw();
    add_instr(OP_LW, 0, 0);
    run_trace("lw");
  endtask

  task automatic test_rtype_beq();
    add_instr(OP_R, 0, 0);
    add_instr(OP_BEQ, 0, 0);
    run_trace("rtype_beq");
  endtask

  task automatic test_sw_stall();
    add_instr(OP_SW, 0, 3);
    add_instr(OP_J, 0, 0);
    run_trace("sw_stall");
  endtask

  task automatic test_read_timeout();
    add_instr(OP_LW, 0, LIMIT);
    add_instr(OP_ADDI, LIMIT - 1, 0);
    add_instr(OP_J, LIMIT, 0);
    add_instr(OP_SW, 0, LIMIT);
    add_instr(OP_R, 0, 0);
    run_trace("timeout");
  endtask

  task automatic test_illegal();
    add_instr(6'b111111, 0, 0);
    add_instr(OP_ADDI, 0, 0);
    run_trace("illegal");
  endtask

  task automatic test_async_reset();
    add(ST_FETCH, 1'b1, OP_R);
    add(ST_DECODE, 1'b0, OP_R);
    add(ST_EXEC, 1'b1, OP_R);
    run_trace("async_pre");
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (state !== ST_ALUWB || RegWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL async_alu_wb: got st=%0d RegWrite=%b expected 7/1", state, RegWrite);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (state !== ST_FETCH || RegWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_now: got st=%0d RegWrite=%b expected 0/0", state, RegWrite);
    end
    vectors++;
    if (act_ctrl !== exp_ctrl(ST_FETCH, 1'b0) || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_ctrl: got %h expected %h", act_ctrl, exp_ctrl(ST_FETCH, 1'b0));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    pend_ill = 1'b0;
    pend_to  = 1'b0;
    add_instr(OP_LW, 1, 1);
    run_trace("async_post");
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [5:0] op;
    int fs, ms;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_BEQ;
    ops[4] = OP_J;  ops[5] = OP_ADDI; ops[6] = 6'b111111; ops[7] = 6'b000000;
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      fs = ($urandom_range(0, 9) == 0) ? LIMIT : $urandom_range(0, LIMIT - 1);
      ms = ($urandom_range(0, 5) == 0) ? LIMIT : $urandom_range(0, LIMIT - 1);
      add_instr(op, fs, ms);
      run_trace("random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_beq();
    test_sw_stall();
    test_read_timeout();
    test_illegal();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
